// File: rtl/ps2_host_tx_if.sv
// Command-side bus of the PS/2 host transmitter: byte request/accept plus status.
// The master issues commands; the slave (transmitter) reports ready/busy/done/error.
interface ps2_host_tx_if;
  logic [7:0] cmd_data;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       busy;
  logic       done;
  logic       error;

  modport master (
    output cmd_data,
    output cmd_valid,
    input  cmd_ready,
    input  busy,
    input  done,
    input  error
  );

  modport slave (
    input  cmd_data,
    input  cmd_valid,
    output cmd_ready,
    output busy,
    output done,
    output error
  );
endinterface

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device byte transmitter: inhibit, request-to-send, clock out
// data/parity/stop on device falling edges, then check ACK and wait for idle.
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 5000,
  parameter int unsigned RTS_CYCLES     = 50,
  parameter int unsigned START_TIMEOUT  = 750000,
  parameter int unsigned BIT_TIMEOUT    = 100000
) (
  input  logic         clk,
  input  logic         reset,
  ps2_host_tx_if.slave cmd_if,
  input  logic         i_ps2_clk_in,
  input  logic         i_ps2_dat_in,
  output logic         o_ps2_clk_oe,
  output logic         o_ps2_dat_oe
);

  localparam int unsigned PH_MAX = (INHIBIT_CYCLES > RTS_CYCLES) ? INHIBIT_CYCLES : RTS_CYCLES;
  localparam int unsigned TO_MAX = (START_TIMEOUT > BIT_TIMEOUT) ? START_TIMEOUT : BIT_TIMEOUT;
  localparam int unsigned PH_W   = $clog2(PH_MAX + 1);
  localparam int unsigned TO_W   = $clog2(TO_MAX + 1);
  localparam int unsigned BIT_W  = 4;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    RTS,
    SEND,
    WAIT_ACK,
    WAIT_IDLE
  } state_t;

  state_t             r_state;
  logic [7:0]         r_data;
  logic               r_parity;
  logic [BIT_W-1:0]   r_bit_cnt;
  logic [PH_W-1:0]    r_ph_cnt;
  logic [TO_W-1:0]    r_to_cnt;
  logic               r_clk_oe;
  logic               r_dat_oe;
  logic               r_ready;
  logic               r_busy;
  logic               r_done;
  logic               r_error;

  logic               r_clk_s1;
  logic               r_clk_s2;
  logic               r_clk_prev;
  logic               r_dat_s1;
  logic               r_dat_s2;

  state_t             w_state_nxt;
  logic [7:0]         w_data_nxt;
  logic               w_parity_nxt;
  logic [BIT_W-1:0]   w_bit_nxt;
  logic [PH_W-1:0]    w_ph_nxt;
  logic [TO_W-1:0]    w_to_nxt;
  logic               w_clk_oe_nxt;
  logic               w_dat_oe_nxt;
  logic               w_done_nxt;
  logic               w_error_nxt;
  logic               w_timeout;
  logic [TO_W-1:0]    w_to_limit;
  logic               w_fall;

  // Two-flop synchronizers; line idle level is high.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_clk_s1   <= 1'b1;
      r_clk_s2   <= 1'b1;
      r_clk_prev <= 1'b1;
      r_dat_s1   <= 1'b1;
      r_dat_s2   <= 1'b1;
    end else begin
      r_clk_s1   <= i_ps2_clk_in;
      r_clk_s2   <= r_clk_s1;
      r_clk_prev <= r_clk_s2;
      r_dat_s1   <= i_ps2_dat_in;
      r_dat_s2   <= r_dat_s1;
    end
  end

  assign w_fall = r_clk_prev & ~r_clk_s2;

  // First device edge may take much longer than the inter-bit gap.
  assign w_to_limit = ((r_state == SEND) && (r_bit_cnt == BIT_W'(0)))
                    ? TO_W'(START_TIMEOUT) : TO_W'(BIT_TIMEOUT);

  // State register and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_data    <= 8'h00;
      r_parity  <= 1'b0;
      r_bit_cnt <= '0;
      r_ph_cnt  <= '0;
      r_to_cnt  <= '0;
      r_clk_oe  <= 1'b0;
      r_dat_oe  <= 1'b0;
      r_ready   <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_error   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_data    <= w_data_nxt;
      r_parity  <= w_parity_nxt;
      r_bit_cnt <= w_bit_nxt;
      r_ph_cnt  <= w_ph_nxt;
      r_to_cnt  <= w_to_nxt;
      r_clk_oe  <= w_clk_oe_nxt;
      r_dat_oe  <= w_dat_oe_nxt;
      r_ready   <= (w_state_nxt == IDLE);
      r_busy    <= (w_state_nxt != IDLE);
      r_done    <= w_done_nxt;
      r_error   <= w_error_nxt;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt  = r_state;
    w_data_nxt   = r_data;
    w_parity_nxt = r_parity;
    w_bit_nxt    = r_bit_cnt;
    w_ph_nxt     = r_ph_cnt;
    w_to_nxt     = r_to_cnt;
    w_clk_oe_nxt = r_clk_oe;
    w_dat_oe_nxt = r_dat_oe;
    w_done_nxt   = 1'b0;
    w_error_nxt  = 1'b0;
    w_timeout    = 1'b0;

    if (r_state == IDLE) begin
      w_clk_oe_nxt = 1'b0;
      w_dat_oe_nxt = 1'b0;
      if (cmd_if.cmd_valid && r_ready) begin
        w_data_nxt   = cmd_if.cmd_data;
        w_parity_nxt = ~^cmd_if.cmd_data;
        w_bit_nxt    = '0;
        w_ph_nxt     = '0;
        w_to_nxt     = '0;
        w_clk_oe_nxt = 1'b1;
        w_state_nxt  = INHIBIT;
      end
    end else if (r_state == INHIBIT) begin
      if (r_ph_cnt == PH_W'(INHIBIT_CYCLES - 1)) begin
        w_ph_nxt     = '0;
        w_dat_oe_nxt = 1'b1;
        w_state_nxt  = RTS;
      end else begin
        w_ph_nxt = r_ph_cnt + PH_W'(1);
      end
    end else if (r_state == RTS) begin
      // Release clock while keeping data low as the start bit.
      if (r_ph_cnt == PH_W'(RTS_CYCLES - 1)) begin
        w_ph_nxt     = '0;
        w_to_nxt     = '0;
        w_bit_nxt    = '0;
        w_clk_oe_nxt = 1'b0;
        w_state_nxt  = SEND;
      end else begin
        w_ph_nxt = r_ph_cnt + PH_W'(1);
      end
    end else begin
      // SEND, WAIT_ACK, WAIT_IDLE share the edge-restarted watchdog.
      if (w_fall) begin
        w_to_nxt = '0;
      end else if (r_to_cnt >= w_to_limit) begin
        w_timeout = 1'b1;
      end else begin
        w_to_nxt = r_to_cnt + TO_W'(1);
      end

      if (w_timeout) begin
        w_to_nxt     = '0;
        w_clk_oe_nxt = 1'b0;
        w_dat_oe_nxt = 1'b0;
        w_error_nxt  = 1'b1;
        w_state_nxt  = IDLE;
      end else if (r_state == SEND) begin
        if (w_fall) begin
          w_bit_nxt = r_bit_cnt + BIT_W'(1);
          if (r_bit_cnt < BIT_W'(8)) begin
            w_dat_oe_nxt = ~r_data[r_bit_cnt[2:0]];
          end else if (r_bit_cnt == BIT_W'(8)) begin
            w_dat_oe_nxt = ~r_parity;
          end else begin
            w_dat_oe_nxt = 1'b0;
            w_state_nxt  = WAIT_ACK;
          end
        end
      end else if (r_state == WAIT_ACK) begin
        if (w_fall) begin
          if (!r_dat_s2) begin
            w_state_nxt = WAIT_IDLE;
          end else begin
            w_clk_oe_nxt = 1'b0;
            w_dat_oe_nxt = 1'b0;
            w_error_nxt  = 1'b1;
            w_state_nxt  = IDLE;
          end
        end
      end else begin
        if (r_clk_s2 && r_dat_s2) begin
          w_done_nxt  = 1'b1;
          w_state_nxt = IDLE;
        end
      end
    end
  end

  assign o_ps2_clk_oe     = r_clk_oe;
  assign o_ps2_dat_oe     = r_dat_oe;
  assign cmd_if.cmd_ready = r_ready;
  assign cmd_if.busy      = r_busy;
  assign cmd_if.done      = r_done;
  assign cmd_if.error     = r_error;

endmodule
